// File: rtl/sum_mult_e_requant_pkg.sv
// Shared constants, mode encoding and shift clamp for the sum*E requantizer.
// Build option: SUM_MULT_E_REQUANT_SATCNT_EN adds a saturation counter to the top.
package sum_mult_e_requant_pkg;

  localparam int unsigned COLUMN_NUM_IN_SA    = 16;
  localparam int unsigned PE_PARALLEL_PIXEL   = 2;
  localparam int unsigned PE_PARALLEL_WEIGHT  = 2;
  localparam int unsigned LANE_NUM            = PE_PARALLEL_PIXEL * PE_PARALLEL_WEIGHT *
                                                COLUMN_NUM_IN_SA;
  localparam int unsigned HALF_LANES          = LANE_NUM / 2;
  localparam int unsigned MULT_P_WIDTH        = 40;
  localparam int unsigned SHIFT_WIDTH         = 6;
  localparam int unsigned OUT_WIDTH           = 8;
  localparam int unsigned SAT_CNT_WIDTH       = 16;

  localparam int unsigned SHIFT_MAX = 39;
  localparam int          INT8_MAX  = 127;
  localparam int          INT8_MIN  = -128;

  typedef enum logic {
    MODE_88 = 1'b0,
    MODE_18 = 1'b1
  } mode_e;

  // Shifts beyond the product width would discard everything, so cap them.
  function automatic logic [SHIFT_WIDTH-1:0] clamp_shift(input logic [SHIFT_WIDTH-1:0] s);
    return (s > SHIFT_WIDTH'(SHIFT_MAX)) ? SHIFT_WIDTH'(SHIFT_MAX) : s;
  endfunction

endpackage

// File: rtl/sum_mult_e_requant_if.sv
// Input/output handshake bundle of the requantizer; slave is the block side.
interface sum_mult_e_requant_if;
  import sum_mult_e_requant_pkg::*;

  logic                                      mode;
  logic                                      in_valid;
  logic                                      in_ready;
  logic [LANE_NUM*MULT_P_WIDTH-1:0]          P_vector;
  logic [SHIFT_WIDTH*PE_PARALLEL_WEIGHT-1:0] shift_set;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [LANE_NUM*OUT_WIDTH-1:0]             out_vector;

  modport master (
    output mode, in_valid, P_vector, shift_set, out_ready,
    input  in_ready, out_valid, out_vector
  );

  modport slave (
    input  mode, in_valid, P_vector, shift_set, out_ready,
    output in_ready, out_valid, out_vector
  );

endinterface

// File: rtl/sum_mult_e_requant_lane.sv
// One combinational requant lane: rounding arithmetic right shift then int8 saturation.
// o_sat exists only when SUM_MULT_E_REQUANT_SATCNT_EN is defined.
module requant_lane
  import sum_mult_e_requant_pkg::*;
(
  input  logic [MULT_P_WIDTH-1:0] i_p,
  input  logic [SHIFT_WIDTH-1:0]  i_shift,
`ifdef SUM_MULT_E_REQUANT_SATCNT_EN
  output logic                    o_sat,
`endif
  output logic [OUT_WIDTH-1:0]    o_q
);

  logic signed [MULT_P_WIDTH:0] w_ext;
  logic signed [MULT_P_WIDTH:0] w_bias;
  logic signed [MULT_P_WIDTH:0] w_sum;
  logic signed [MULT_P_WIDTH:0] w_shr;
  logic                         w_pos_sat;
  logic                         w_neg_sat;

  // One extra bit keeps the half-LSB bias from overflowing at the positive limit.
  assign w_ext  = {i_p[MULT_P_WIDTH-1], i_p};
  assign w_bias = (i_shift == '0) ? '0 : ((MULT_P_WIDTH+1)'(1) << (i_shift - SHIFT_WIDTH'(1)));
  assign w_sum  = w_ext + w_bias;
  assign w_shr  = w_sum >>> i_shift;

  assign w_pos_sat = w_shr > (MULT_P_WIDTH+1)'(INT8_MAX);
  assign w_neg_sat = w_shr < (MULT_P_WIDTH+1)'(INT8_MIN);

  always_comb begin
    o_q = w_shr[OUT_WIDTH-1:0];
    if (w_pos_sat) begin
      o_q = OUT_WIDTH'(INT8_MAX);
    end else if (w_neg_sat) begin
      o_q = OUT_WIDTH'(INT8_MIN);
    end
  end

`ifdef SUM_MULT_E_REQUANT_SATCNT_EN
  assign o_sat = w_pos_sat | w_neg_sat;
`endif

endmodule

// File: rtl/sum_mult_e_requant.sv
// Two-stage valid/ready requantizer: registers products, then int8 results per lane.
// Build option: SUM_MULT_E_REQUANT_SATCNT_EN adds sat_clear/sat_count.
module sum_mult_e_requant
  import sum_mult_e_requant_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
`ifdef SUM_MULT_E_REQUANT_SATCNT_EN
  input  logic                     sat_clear,
  output logic [SAT_CNT_WIDTH-1:0] sat_count,
`endif
  sum_mult_e_requant_if.slave      bus
);

  logic                             w_in_fire;
  logic                             w_s2_load;
  logic                             w_s1_adv;

  logic                             r_s1_valid;
  logic [LANE_NUM*MULT_P_WIDTH-1:0] r_s1_p;
  mode_e                            r_s1_mode;
  logic [SHIFT_WIDTH-1:0]           r_s1_sh0;
  logic [SHIFT_WIDTH-1:0]           r_s1_sh1;

  logic                             r_s2_valid;
  logic [LANE_NUM*OUT_WIDTH-1:0]    r_s2_out;

  logic [LANE_NUM*OUT_WIDTH-1:0]    w_q_vec;
  logic [LANE_NUM-1:0]              w_active;

  // in_ready depends on out_ready and state only, never on in_valid.
  assign w_s2_load    = !r_s2_valid | bus.out_ready;
  assign w_s1_adv     = r_s1_valid & w_s2_load;
  assign bus.in_ready = !r_s1_valid | w_s2_load;
  assign w_in_fire    = bus.in_valid & bus.in_ready;

  assign bus.out_valid  = r_s2_valid;
  assign bus.out_vector = r_s2_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_p     <= '0;
      r_s1_mode  <= MODE_88;
      r_s1_sh0   <= '0;
      r_s1_sh1   <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_p     <= bus.P_vector;
      r_s1_mode  <= mode_e'(bus.mode);
      r_s1_sh0   <= clamp_shift(bus.shift_set[SHIFT_WIDTH-1:0]);
      r_s1_sh1   <= clamp_shift(bus.shift_set[2*SHIFT_WIDTH-1:SHIFT_WIDTH]);
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_out   <= '0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s1_adv) begin
        r_s2_out <= w_q_vec;
      end
    end
  end

`ifdef SUM_MULT_E_REQUANT_SATCNT_EN
  logic [LANE_NUM-1:0] w_sat;
`endif

  // Upper half of the lanes carries channel 1 in 1x8 mode and is idle in 8x8 mode.
  for (genvar g = 0; g < LANE_NUM; g++) begin : g_lane
    logic [SHIFT_WIDTH-1:0] w_shift;
    logic [OUT_WIDTH-1:0]   w_q;

    assign w_active[g] = (g < HALF_LANES) || (r_s1_mode == MODE_18);
    assign w_shift     = ((g >= HALF_LANES) && (r_s1_mode == MODE_18)) ? r_s1_sh1 : r_s1_sh0;

`ifdef SUM_MULT_E_REQUANT_SATCNT_EN
    logic w_lane_sat;

    requant_lane u_lane (
      .i_p     (r_s1_p[g*MULT_P_WIDTH +: MULT_P_WIDTH]),
      .i_shift (w_shift),
      .o_sat   (w_lane_sat),
      .o_q     (w_q)
    );

    assign w_sat[g] = w_active[g] & w_lane_sat;
`else
    requant_lane u_lane (
      .i_p     (r_s1_p[g*MULT_P_WIDTH +: MULT_P_WIDTH]),
      .i_shift (w_shift),
      .o_q     (w_q)
    );
`endif

    assign w_q_vec[g*OUT_WIDTH +: OUT_WIDTH] = w_active[g] ? w_q : '0;
  end

`ifdef SUM_MULT_E_REQUANT_SATCNT_EN
  logic [6:0]               w_sat_num;
  logic [SAT_CNT_WIDTH:0]   w_cnt_sum;
  logic [SAT_CNT_WIDTH-1:0] r_sat_count;

  always_comb begin
    w_sat_num = '0;
    for (int i = 0; i < LANE_NUM; i++) begin
      w_sat_num = w_sat_num + 7'(w_sat[i]);
    end
  end

  assign w_cnt_sum = {1'b0, r_sat_count} + (SAT_CNT_WIDTH+1)'(w_sat_num);

  // Clear has priority over a same-cycle increment; the count pins at all-ones.
  always_ff @(posedge clk) begin
    if (rst || sat_clear) begin
      r_sat_count <= '0;
    end else if (w_s1_adv) begin
      r_sat_count <= w_cnt_sum[SAT_CNT_WIDTH] ? '1 : w_cnt_sum[SAT_CNT_WIDTH-1:0];
    end
  end

  assign sat_count = r_sat_count;
`endif

endmodule
